// File: rtl/piso_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : piso_shift_reg
//  Description : Parallel-in, serial-out shift register. A WIDTH-bit word is
//                captured on the load strobe and then presented one bit per
//                clock on a single serial output, MSB-first or LSB-first.
//
//  Ports       : clk - clock, all state changes on the rising edge
//                rst - synchronous active-high reset (clears the register)
//                l   - load strobe: 1 = capture i this edge, 0 = shift
//                i   - parallel data word [WIDTH-1:0]
//                o   - serial data output
//
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_shift_reg #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             l,
  input  logic [WIDTH-1:0] i,
  output logic             o
);

  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_shifted;
  logic             w_out;

  // Shift direction and output tap are fixed at elaboration. Vacated bit
  // positions fill with zero, so an exhausted word drives o low until the
  // next load or reset.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_shifted = {r_sr[WIDTH-2:0], 1'b0};
      assign w_out     = r_sr[WIDTH-1];
    end else begin : g_lsb_first
      assign w_shifted = {1'b0, r_sr[WIDTH-1:1]};
      assign w_out     = r_sr[0];
    end
  endgenerate

  // Priority: reset, then load, then shift. A load simply overwrites
  // whatever bits remain, so a mid-word reload restarts cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr <= '0;
    end else if (l) begin
      r_sr <= i;
    end else begin
      r_sr <= w_shifted;
    end
  end

  // Output depends on the register only; no combinational path from i or l.
  assign o = w_out;

endmodule
`default_nettype wire

// File: tb/tb_piso_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_shift_reg
//  Description : Self-checking bench for piso_shift_reg. Three instances
//                (4-bit MSB-first, 4-bit LSB-first, 8-bit MSB-first) share
//                clk/rst/l. A word/shift-count model predicts o every cycle;
//                directed literal checks pin the test-plan sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_shift_reg;

  logic       clk;
  logic       rst;
  logic       l;
  logic [3:0] i4;
  logic [7:0] i8;
  logic       o_a;  // WIDTH=4, MSB first
  logic       o_b;  // WIDTH=4, LSB first
  logic       o_c;  // WIDTH=8, MSB first

  int nchk;
  int nerr;

  piso_shift_reg #(.WIDTH(4), .MSB_FIRST(1)) u_a (
    .clk(clk), .rst(rst), .l(l), .i(i4), .o(o_a)
  );
  piso_shift_reg #(.WIDTH(4), .MSB_FIRST(0)) u_b (
    .clk(clk), .rst(rst), .l(l), .i(i4), .o(o_b)
  );
  piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1)) u_c (
    .clk(clk), .rst(rst), .l(l), .i(i8), .o(o_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Model: remember the last loaded word and how many shifts have happened
  // since. The bit on o is the word's k-th bit in presentation order, or 0
  // once all WIDTH bits have been presented.
  // --------------------------------------------------------------------------
  logic [7:0] m_word_a, m_word_b, m_word_c;
  int         m_cnt_a, m_cnt_b, m_cnt_c;
  bit         m_valid;

  function automatic logic model_bit(logic [7:0] word, int cnt, int w, bit msb);
    if (cnt >= w) return 1'b0;
    return msb ? word[w-1-cnt] : word[cnt];
  endfunction

  initial begin
    m_valid = 1'b0;
    m_cnt_a = 0; m_cnt_b = 0; m_cnt_c = 0;
    m_word_a = '0; m_word_b = '0; m_word_c = '0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_word_a = '0; m_word_b = '0; m_word_c = '0;
      m_cnt_a = 0; m_cnt_b = 0; m_cnt_c = 0;
      m_valid = 1'b1;
    end else if (l) begin
      m_word_a = {4'b0, i4}; m_word_b = {4'b0, i4}; m_word_c = i8;
      m_cnt_a = 0; m_cnt_b = 0; m_cnt_c = 0;
      m_valid = 1'b1;
    end else begin
      m_cnt_a++; m_cnt_b++; m_cnt_c++;
    end
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Continuous model comparison, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_a", o_a, model_bit(m_word_a, m_cnt_a, 4, 1'b1));
      chk("model_b", o_b, model_bit(m_word_b, m_cnt_b, 4, 1'b0));
      chk("model_c", o_c, model_bit(m_word_c, m_cnt_c, 8, 1'b1));
    end
  end

  // Drive one edge; inputs change on the falling edge, results sampled
  // 1 time unit after the rising edge.
  task automatic tick(input logic r, input logic ld, input logic [3:0] v4,
                      input logic [7:0] v8);
    @(negedge clk);
    rst = r; l = ld; i4 = v4; i8 = v8;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_c [0:8];
    nchk = 0;
    nerr = 0;
    rst = 1'b0; l = 1'b0; i4 = '0; i8 = '0;

    // Reset state
    tick(1'b1, 1'b0, 4'h0, 8'h00);
    chk("rst_a", o_a, 1'b0);
    chk("rst_b", o_b, 1'b0);
    chk("rst_c", o_c, 1'b0);

    // Basic word 1010: MSB-first 1,0,1,0 ; LSB-first 0,1,0,1
    tick(1'b0, 1'b1, 4'b1010, 8'h3C);
    chk("t1_ld_a", o_a, 1'b1);
    chk("t5_ld_b", o_b, 1'b0);
    tick(1'b0, 1'b0, 4'h0, 8'h00);
    chk("t1_s1_a", o_a, 1'b0);
    chk("t5_s1_b", o_b, 1'b1);
    tick(1'b0, 1'b0, 4'h0, 8'h00);
    chk("t1_s2_a", o_a, 1'b1);
    chk("t5_s2_b", o_b, 1'b0);
    tick(1'b0, 1'b0, 4'h0, 8'h00);
    chk("t1_s3_a", o_a, 1'b0);
    chk("t5_s3_b", o_b, 1'b1);

    // Exhaustion: zeros keep coming
    tick(1'b0, 1'b0, 4'hF, 8'hFF);
    chk("t2_ex1_a", o_a, 1'b0);
    chk("t2_ex1_b", o_b, 1'b0);
    tick(1'b0, 1'b0, 4'hF, 8'hFF);
    chk("t2_ex2_a", o_a, 1'b0);

    // Load 1111: four ones then zero
    tick(1'b0, 1'b1, 4'b1111, 8'h00);
    chk("t2_ld_a", o_a, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, 4'h0, 8'h00);
      chk("t2_ones_a", o_a, 1'b1);
    end
    tick(1'b0, 1'b0, 4'h0, 8'h00);
    chk("t2_tail_a", o_a, 1'b0);

    // Reset wins over a simultaneous load
    tick(1'b0, 1'b1, 4'b1111, 8'hFF);
    chk("t3_ld_a", o_a, 1'b1);
    chk("t3_ld_c", o_c, 1'b1);
    tick(1'b1, 1'b1, 4'b1111, 8'hFF);
    chk("t3_rst_a", o_a, 1'b0);
    chk("t3_rst_b", o_b, 1'b0);
    chk("t3_rst_c", o_c, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, 4'hF, 8'hFF);
      chk("t3_post_a", o_a, 1'b0);
      chk("t3_post_b", o_b, 1'b0);
    end

    // Reload mid-word: 1000, shift, 0111 -> 1, 0, 0, 1, 1, 1
    tick(1'b0, 1'b1, 4'b1000, 8'h00);
    chk("t4_ld1_a", o_a, 1'b1);
    tick(1'b0, 1'b0, 4'h0, 8'h00);
    chk("t4_s1_a", o_a, 1'b0);
    tick(1'b0, 1'b1, 4'b0111, 8'h00);
    chk("t4_ld2_a", o_a, 1'b0);
    chk("t4_ld2_b", o_b, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, 4'h0, 8'h00);
      chk("t4_ones_a", o_a, 1'b1);
    end

    // Holding load: o tracks the most recently loaded word
    tick(1'b0, 1'b1, 4'b1010, 8'h01);
    chk("hold1_a", o_a, 1'b1);
    chk("hold1_b", o_b, 1'b0);
    tick(1'b0, 1'b1, 4'b0101, 8'h80);
    chk("hold2_a", o_a, 1'b0);
    chk("hold2_b", o_b, 1'b1);
    chk("hold2_c", o_c, 1'b1);

    // Reset mid-word, then 8-bit word A5
    tick(1'b1, 1'b0, 4'h0, 8'h00);
    chk("rst2_c", o_c, 1'b0);
    exp_c[0] = 8'd1; exp_c[1] = 8'd0; exp_c[2] = 8'd1; exp_c[3] = 8'd0;
    exp_c[4] = 8'd0; exp_c[5] = 8'd1; exp_c[6] = 8'd0; exp_c[7] = 8'd1;
    exp_c[8] = 8'd0;
    tick(1'b0, 1'b1, 4'h6, 8'hA5);
    chk("t6_ld_c", o_c, exp_c[0][0]);
    for (int k = 1; k <= 8; k++) begin
      tick(1'b0, 1'b0, 4'h0, 8'h00);
      chk("t6_shift_c", o_c, exp_c[k][0]);
    end

    // Let the continuous comparison see the final state
    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
`default_nettype wire
